arith_result_accumulator: RTL and testbench
===========================================

// Module: arith_result_accumulator
//
// PURPOSE
//   Downstream stage of the 3-bit add/multiply datapath. It consumes one result per
//   handshake: either a 4-bit {carry,sum} or a 6-bit product. It accumulates BATCH
//   results into a saturating ACC_W-bit total, then holds the total for the consumer
//   behind a valid/ready handshake. The arithmetic core stays combinational; this
//   block adds the registered, flow-controlled boundary.
//
// PARAMETERS
//   ACC_W   10  accumulator / out_acc width in bits; must be >= 6
//   BATCH    4  results per batch; must be >= 1
//   CNT_W    3  width of out_count; must satisfy 2**CNT_W > BATCH
//
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      upstream result present
//   in_ready   out  1      block accepts a result this cycle
//   in_mode    in   1      1 = adder result (in_data[3:0] only), 0 = product (in_data[5:0])
//   in_data    in   6      result from the arithmetic stage
//   clear      in   1      synchronous batch abort / flush
//   out_valid  out  1      completed batch total presented
//   out_ready  in   1      consumer takes the total
//   out_acc    out  ACC_W  accumulator: running total in ACCUM, final total in HOLD
//   out_count  out  CNT_W  results accepted in the current batch
//   out_sat    out  1      sticky: the batch saturated at least once
//
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=ACCUM, acc=0, count=0, sat=0.
//   - Outputs: in_ready=1, out_valid=0, out_acc=0, out_count=0, out_sat=0.
// - All outputs come directly from registers or the state register.
//   No combinational path from in_valid/in_data to any output.
// - in_ready = (state==ACCUM) && !clear.
// - out_valid = (state==HOLD).
// - Transfer (ACCUM only): in_valid && in_ready at the clock edge.
//   - Operand = in_mode ? {0, in_data[3:0]} : {0, in_data[5:0]}, zero-extended to ACC_W.
//     In adder mode, in_data[5:4] are ignored.
//   - acc <= min(acc + operand, 2**ACC_W-1). Compute the sum in ACC_W+1 bits.
//   - On clamp, sat <= 1; sat stays set until the batch ends.
//   - count <= count+1.
//   - If count==BATCH-1 before the edge, state <= HOLD. out_valid rises on that edge,
//     so latency from the last input edge to out_valid is 1 cycle.
// - HOLD:
//   - in_ready=0. in_valid and in_data are ignored.
//   - out_acc, out_count (=BATCH) and out_sat stay stable until the handshake completes.
//   - out_valid && out_ready: acc, count, sat <= 0; state <= ACCUM.
//     in_ready returns on the next cycle; no same-cycle bypass.
// - clear (synchronous, priority over transfer and out handshake):
//   - ACCUM: acc, count, sat <= 0. in_ready is low that cycle, so no beat is lost silently.
//   - HOLD: the result is discarded. acc, count, sat <= 0; state <= ACCUM; out_valid
//     falls next cycle.
// - Assertion of rst_n=0 mid-batch or in HOLD returns the block to reset values
//   immediately (async). Deassertion takes effect at the next clock edge.
// - Saturated value: 2**ACC_W-1. Further transfers in the same batch keep that value.
// - No wrap-around of acc is ever permitted.
//
// TESTING
// 1 Multiply batch (BATCH=4, ACC_W=10): products 49, 30, 9, 0 with in_valid held high
//   -> out_valid 1 cycle after 4th beat, out_acc=88, out_count=4, out_sat=0.
// 2 Adder mode: in_mode=1, in_data=6'b110101, four beats -> out_acc=20;
//   in_data[5:4] are shown to be ignored.
// 3 Saturation (ACC_W=6): beats 49, 30, 5, 1 -> out_acc=63 after beat 2 and stays 63;
//   out_sat=1; out_sat=0 after the handshake.
// 4 Backpressure: out_ready=0 for 5 cycles in HOLD while in_valid=1 toggles data
//   -> out_acc, out_count, out_sat stable; in_ready=0. With out_ready=1, in_ready=1
//   next cycle and acc=0.
// 5 Clear: clear in ACCUM after 2 beats -> count=0, acc=0, the beat offered with
//   clear is not taken. clear in HOLD -> out_valid=0 next cycle, no handshake needed.
// 6 Async reset in HOLD and mid-batch (count=2) -> all outputs at reset values before
//   the next edge; a fresh batch then completes correctly.

Source files
------------

// File: rtl/arith_result_accumulator.sv
// Accumulates BATCH add/multiply results into a saturating total and presents it
// behind a valid/ready handshake; clear aborts the current batch or held total.
//
// state | meaning
// ACCUM | accepting results, out_acc is the running total
// HOLD  | batch complete, total held until out_ready or clear
module arith_result_accumulator #(
    parameter int ACC_W = 10,
    parameter int BATCH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [5:0]       in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;
    logic [ACC_W-1:0]   operand;
    logic [ACC_W:0]     sum;
    logic               xfer;

    always_comb begin
        operand = in_mode ? ACC_W'(in_data[3:0]) : ACC_W'(in_data);
        sum     = {1'b0, acc_q} + {1'b0, operand};
        xfer    = in_valid && (state_q == ACCUM) && !clear;
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (clear || ((state_q == HOLD) && out_ready)) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (xfer) begin
            // the extra carry bit of sum flags a clamp to all-ones
            acc_d   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            sat_d   = sat_q | sum[ACC_W];
            count_d = count_q + 1'b1;
            if (count_q == LAST_CNT) begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == ACCUM) && !clear;
    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_count = count_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_arith_result_accumulator.sv
// Directed bench for arith_result_accumulator: a 10-bit and a 6-bit instance share
// stimulus; each scenario task checks the instance it targets.
module tb_arith_result_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_mode = 1'b0;
    logic [5:0] in_data = '0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;

    logic       ir10, ov10, sat10;
    logic [9:0] acc10;
    logic [2:0] cnt10;
    logic       ir6, ov6, sat6;
    logic [5:0] acc6;
    logic [2:0] cnt6;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arith_result_accumulator #(.ACC_W(10), .BATCH(4), .CNT_W(3)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir10),
        .in_mode(in_mode), .in_data(in_data), .clear(clear),
        .out_valid(ov10), .out_ready(out_ready),
        .out_acc(acc10), .out_count(cnt10), .out_sat(sat10)
    );

    arith_result_accumulator #(.ACC_W(6), .BATCH(4), .CNT_W(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir6),
        .in_mode(in_mode), .in_data(in_data), .clear(clear),
        .out_valid(ov6), .out_ready(out_ready),
        .out_acc(acc6), .out_count(cnt6), .out_sat(sat6)
    );

    task automatic do_reset();
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic mode, input logic [5:0] d);
        in_valid = 1'b1; in_mode = mode; in_data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (ir10 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ir10); end
        checks++; if (ov10 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov10); end
        checks++; if (acc10 !== 10'd0) begin errors++; $display("FAIL reset_acc got %0d exp 0", acc10); end
        checks++; if (cnt10 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt10); end
        checks++; if (sat10 !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", sat10); end
        do_reset();
    endtask

    task automatic test_multiply();
        do_reset();
        beat(1'b0, 6'd49);
        beat(1'b0, 6'd30);
        beat(1'b0, 6'd9);
        checks++; if (ov10 !== 1'b0) begin errors++; $display("FAIL mul_valid_early got %b exp 0", ov10); end
        checks++; if (acc10 !== 10'd88 || cnt10 !== 3'd3) begin errors++; $display("FAIL mul_partial got acc=%0d cnt=%0d exp acc=88 cnt=3", acc10, cnt10); end
        beat(1'b0, 6'd0);
        in_valid = 1'b0;
        checks++; if (ov10 !== 1'b1) begin errors++; $display("FAIL mul_valid got %b exp 1", ov10); end
        checks++; if (acc10 !== 10'd88) begin errors++; $display("FAIL mul_acc got %0d exp 88", acc10); end
        checks++; if (cnt10 !== 3'd4) begin errors++; $display("FAIL mul_count got %0d exp 4", cnt10); end
        checks++; if (sat10 !== 1'b0 || ir10 !== 1'b0) begin errors++; $display("FAIL mul_sat_ready got sat=%b rdy=%b exp sat=0 rdy=0", sat10, ir10); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (ov10 !== 1'b0 || acc10 !== 10'd0 || cnt10 !== 3'd0 || ir10 !== 1'b1) begin
            errors++; $display("FAIL mul_handshake got v=%b acc=%0d cnt=%0d rdy=%b exp v=0 acc=0 cnt=0 rdy=1", ov10, acc10, cnt10, ir10);
        end
    endtask

    task automatic test_adder();
        do_reset();
        for (int i = 0; i < 4; i++) beat(1'b1, 6'b110101);
        in_valid = 1'b0;
        checks++; if (acc10 !== 10'd20) begin errors++; $display("FAIL add_acc got %0d exp 20", acc10); end
        checks++; if (ov10 !== 1'b1 || cnt10 !== 3'd4) begin errors++; $display("FAIL add_done got v=%b cnt=%0d exp v=1 cnt=4", ov10, cnt10); end
    endtask

    task automatic test_saturation();
        do_reset();
        beat(1'b0, 6'd49);
        checks++; if (acc6 !== 6'd49 || sat6 !== 1'b0) begin errors++; $display("FAIL sat_beat1 got acc=%0d sat=%b exp acc=49 sat=0", acc6, sat6); end
        beat(1'b0, 6'd30);
        checks++; if (acc6 !== 6'd63 || sat6 !== 1'b1) begin errors++; $display("FAIL sat_beat2 got acc=%0d sat=%b exp acc=63 sat=1", acc6, sat6); end
        beat(1'b0, 6'd5);
        beat(1'b0, 6'd1);
        in_valid = 1'b0;
        checks++; if (acc6 !== 6'd63 || sat6 !== 1'b1 || ov6 !== 1'b1) begin errors++; $display("FAIL sat_final got acc=%0d sat=%b v=%b exp acc=63 sat=1 v=1", acc6, sat6, ov6); end
        checks++; if (acc10 !== 10'd85 || sat10 !== 1'b0) begin errors++; $display("FAIL sat_wide got acc=%0d sat=%b exp acc=85 sat=0", acc10, sat10); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (sat6 !== 1'b0 || acc6 !== 6'd0) begin errors++; $display("FAIL sat_clear got acc=%0d sat=%b exp acc=0 sat=0", acc6, sat6); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) beat(1'b0, 6'd7);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = (i % 2 == 0) ? 6'd63 : 6'd1;
            @(posedge clk); #1;
            checks++; if (acc10 !== 10'd28 || cnt10 !== 3'd4 || sat10 !== 1'b0 || ov10 !== 1'b1 || ir10 !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got acc=%0d cnt=%0d sat=%b v=%b rdy=%b exp acc=28 cnt=4 sat=0 v=1 rdy=0", i, acc10, cnt10, sat10, ov10, ir10);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (ir10 !== 1'b1 || acc10 !== 10'd0 || ov10 !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b acc=%0d v=%b exp rdy=1 acc=0 v=0", ir10, acc10, ov10);
        end
    endtask

    task automatic test_clear();
        do_reset();
        beat(1'b0, 6'd10);
        beat(1'b0, 6'd20);
        checks++; if (acc10 !== 10'd30 || cnt10 !== 3'd2) begin errors++; $display("FAIL clr_pre got acc=%0d cnt=%0d exp acc=30 cnt=2", acc10, cnt10); end
        in_valid = 1'b1; in_data = 6'd5; clear = 1'b1;
        #1;
        checks++; if (ir10 !== 1'b0) begin errors++; $display("FAIL clr_ready got %b exp 0", ir10); end
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        checks++; if (acc10 !== 10'd0 || cnt10 !== 3'd0) begin errors++; $display("FAIL clr_accum got acc=%0d cnt=%0d exp acc=0 cnt=0", acc10, cnt10); end
        beat(1'b0, 6'd1); beat(1'b0, 6'd2); beat(1'b0, 6'd3); beat(1'b0, 6'd4);
        in_valid = 1'b0;
        checks++; if (ov10 !== 1'b1 || acc10 !== 10'd10) begin errors++; $display("FAIL clr_batch got v=%b acc=%0d exp v=1 acc=10", ov10, acc10); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (ov10 !== 1'b0 || acc10 !== 10'd0 || cnt10 !== 3'd0) begin
            errors++; $display("FAIL clr_hold got v=%b acc=%0d cnt=%0d exp v=0 acc=0 cnt=0", ov10, acc10, cnt10);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) beat(1'b0, 6'd11);
        in_valid = 1'b0;
        checks++; if (ov10 !== 1'b1 || acc10 !== 10'd44) begin errors++; $display("FAIL ar_hold got v=%b acc=%0d exp v=1 acc=44", ov10, acc10); end
        rst_n = 1'b0;
        #2;
        checks++; if (ov10 !== 1'b0 || acc10 !== 10'd0 || cnt10 !== 3'd0 || ir10 !== 1'b1) begin
            errors++; $display("FAIL ar_in_hold got v=%b acc=%0d cnt=%0d rdy=%b exp v=0 acc=0 cnt=0 rdy=1", ov10, acc10, cnt10, ir10);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(1'b0, 6'd12); beat(1'b0, 6'd13);
        in_valid = 1'b0;
        checks++; if (cnt10 !== 3'd2 || acc10 !== 10'd25) begin errors++; $display("FAIL ar_mid_pre got cnt=%0d acc=%0d exp cnt=2 acc=25", cnt10, acc10); end
        rst_n = 1'b0;
        #2;
        checks++; if (cnt10 !== 3'd0 || acc10 !== 10'd0 || sat10 !== 1'b0) begin
            errors++; $display("FAIL ar_mid got cnt=%0d acc=%0d sat=%b exp cnt=0 acc=0 sat=0", cnt10, acc10, sat10);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(1'b1, 6'd3); beat(1'b0, 6'd40); beat(1'b1, 6'd63); beat(1'b0, 6'd2);
        in_valid = 1'b0;
        checks++; if (ov10 !== 1'b1 || acc10 !== 10'd60 || cnt10 !== 3'd4) begin
            errors++; $display("FAIL ar_fresh got v=%b acc=%0d cnt=%0d exp v=1 acc=60 cnt=4", ov10, acc10, cnt10);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_adder();
        test_saturation();
        test_backpressure();
        test_clear();
        test_async_reset();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
